// File: rtl/ingress_scheduler.sv
// ingress_scheduler: two-lane ingress buffer and round-robin feeder for the main FIFO.
// Each source lane has its own small FIFO. One word per cycle is pushed to the
// main FIFO input, gated by the state-machine active flag and the main FIFO pause.
// Optional per-VC push counters (cnt_vc0/cnt_vc1) are compiled in when the
// macro INGRESS_CNT_EN is defined; without it those ports and that logic are absent.
module ingress_scheduler #(
  parameter int WORD_SIZE = 6,
  parameter int BUF_DEPTH = 4,
  parameter int PTR_L     = 2,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic                 main_pause,
  input  logic [WORD_SIZE-1:0] src0_data,
  input  logic                 src0_valid,
  output logic                 src0_ready,
  input  logic [WORD_SIZE-1:0] src1_data,
  input  logic                 src1_valid,
  output logic                 src1_ready,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 push_out,
  output logic                 idle,
  output logic                 err
`ifdef INGRESS_CNT_EN
  ,
  output logic [CNT_W-1:0]     cnt_vc0,
  output logic [CNT_W-1:0]     cnt_vc1
`endif
);

  localparam logic [PTR_L:0] FULL_COUNT = (PTR_L+1)'(BUF_DEPTH);

  logic [WORD_SIZE-1:0] mem [2][BUF_DEPTH];
  logic [PTR_L-1:0]     wr_ptr [2];
  logic [PTR_L-1:0]     rd_ptr [2];
  logic [PTR_L:0]       count [2];
  logic [WORD_SIZE-1:0] in_data [2];
  logic [1:0]           in_valid;
  logic [1:0]           in_ready;
  logic [1:0]           wr_en;
  logic [1:0]           non_empty;
  logic [1:0]           pop;
  logic                 grant;
  logic                 sel;
  logic                 rr_last;
  logic [WORD_SIZE-1:0] head;

  assign in_valid   = {src1_valid, src0_valid};
  assign in_data[0] = src0_data;
  assign in_data[1] = src1_data;
  assign src0_ready = in_ready[0];
  assign src1_ready = in_ready[1];

  // Per-lane full/empty flags derived from the occupancy counts alone.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_ready[i]  = (count[i] < FULL_COUNT);
      non_empty[i] = (count[i] != '0);
    end
  end

  // A word is taken only while the lane has room; otherwise it is dropped.
  assign wr_en = in_valid & in_ready;

  // Round-robin pick among non-empty lanes, gated by active and the main FIFO pause.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    grant = 1'b0;
    sel   = 1'b0;
    if (active && !main_pause && (non_empty != 2'b00)) begin
      grant = 1'b1;
      sel   = (non_empty == 2'b11) ? ~rr_last : non_empty[1];
    end
  end

  assign pop  = {grant & sel, grant & ~sel};
  assign head = mem[sel][rd_ptr[sel]];

  // Lane storage: written on accept.
  // NOTE: storage has no reset; the occupancy counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i]] <= in_data[i];
    end
  end

  // Lane pointers and occupancy; a same-edge write and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({wr_en[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Registered push to the main FIFO, round-robin history and sticky drop error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_out <= 1'b0;
      data_out <= '0;
      rr_last  <= 1'b1;
      err      <= 1'b0;
    end else begin
      push_out <= grant;
      if (grant) begin
        data_out <= head;
        rr_last  <= sel;
      end
      if ((in_valid & ~in_ready) != 2'b00) err <= 1'b1;
    end
  end

  assign idle = (non_empty == 2'b00) && !push_out;

`ifdef INGRESS_CNT_EN
  // Saturating per-VC counts of pushed words, split on the VC bit of the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_vc0 <= '0;
      cnt_vc1 <= '0;
    end else if (grant) begin
      if (head[WORD_SIZE-1]) begin
        if (cnt_vc1 != '1) cnt_vc1 <= cnt_vc1 + 1'b1;
      end else begin
        if (cnt_vc0 != '1) cnt_vc0 <= cnt_vc0 + 1'b1;
      end
    end
  end
`endif

endmodule
